seq_sm_mul: RTL and testbench



---
 rtl/seq_sm_mul_if.sv | 27 ++
 rtl/seq_sm_mul.sv | 144 ++++++++++++++
 tb/tb_seq_sm_mul.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_sm_mul_if.sv
// Handshake and data bundle between the calculator control FSM and the
// sign-magnitude multiplier.
interface seq_sm_mul_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 sign_a;
    logic                 sign_b;
    logic [2*WIDTH-1:0]   prod_mag;
    logic                 prod_sign;
    logic [WIDTH-1:0]     res;
    logic                 ovf;
    logic                 busy;
    logic                 done;

    modport master (
        output start, a, b, sign_a, sign_b,
        input  prod_mag, prod_sign, res, ovf, busy, done
    );

    modport slave (
        input  start, a, b, sign_a, sign_b,
        output prod_mag, prod_sign, res, ovf, busy, done
    );
endinterface

// File: rtl/seq_sm_mul.sv
// Sequential shift-add sign-magnitude multiplier, one multiplier bit per clock,
// with a W-bit two's-complement result that wraps or saturates on overflow.
//
// state  | meaning
// S_IDLE | waiting for start; result outputs hold their last value
// S_RUN  | one partial product per cycle, WIDTH cycles in total
// S_DONE | results valid, done pulse; start here chains the next multiply
module seq_sm_mul #(
    parameter int WIDTH    = 8,
    parameter bit SAT_MODE = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    seq_sm_mul_if.slave mul_io
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PW-1:0]    MAG_MIN_NEG = PW'(1) << (WIDTH - 1);
    localparam logic [PW-1:0]    MAG_MAX_POS = MAG_MIN_NEG - PW'(1);
    localparam logic [WIDTH-1:0] SAT_POS     = MAG_MAX_POS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_NEG     = MAG_MIN_NEG[WIDTH-1:0];
    localparam logic [CW-1:0]    CNT_LAST    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [PW-1:0]    mcand_q,     mcand_d;
    logic [WIDTH-1:0] mplier_q,    mplier_d;
    logic [PW-1:0]    acc_q,       acc_d;
    logic             sign_q,      sign_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [PW-1:0]    prod_mag_q,  prod_mag_d;
    logic             prod_sign_q, prod_sign_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic             ovf_q,       ovf_d;

    logic [PW-1:0]    fin_mag;
    logic             fin_sign;
    logic             fin_ovf;
    logic [PW-1:0]    fin_tc;
    logic [WIDTH-1:0] fin_res;
    logic             load;

    // Accumulator after this cycle's partial product; on the last RUN cycle
    // this is the complete product, so results are formed from it directly.
    always_comb begin
        fin_mag  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        fin_sign = sign_q & (fin_mag != '0);
        fin_ovf  = fin_sign ? (fin_mag > MAG_MIN_NEG) : (fin_mag > MAG_MAX_POS);
        fin_tc   = fin_sign ? (~fin_mag + PW'(1)) : fin_mag;
        if (fin_ovf && SAT_MODE) begin
            fin_res = fin_sign ? SAT_NEG : SAT_POS;
        end else begin
            fin_res = fin_tc[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        sign_d      = sign_q;
        cnt_d       = cnt_q;
        prod_mag_d  = prod_mag_q;
        prod_sign_d = prod_sign_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        load        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                load = mul_io.start;
            end
            S_RUN: begin
                acc_d    = fin_mag;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    prod_mag_d  = fin_mag;
                    prod_sign_d = fin_sign;
                    res_d       = fin_res;
                    ovf_d       = fin_ovf;
                end
            end
            S_DONE: begin
                load    = mul_io.start;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d  = S_RUN;
            mcand_d  = {{WIDTH{1'b0}}, mul_io.a};
            mplier_d = mul_io.b;
            acc_d    = '0;
            cnt_d    = '0;
            sign_d   = mul_io.sign_a ^ mul_io.sign_b;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            sign_q      <= 1'b0;
            cnt_q       <= '0;
            prod_mag_q  <= '0;
            prod_sign_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            prod_mag_q  <= prod_mag_d;
            prod_sign_q <= prod_sign_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
        end
    end

    assign mul_io.prod_mag  = prod_mag_q;
    assign mul_io.prod_sign = prod_sign_q;
    assign mul_io.res       = res_q;
    assign mul_io.ovf       = ovf_q;
    assign mul_io.busy      = (state_q == S_RUN);
    assign mul_io.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_seq_sm_mul.sv
// Bench for seq_sm_mul: wrap and saturate instances share stimulus and are
// checked every cycle against an arithmetic model, plus hand-computed cases.
module tb_seq_sm_mul;
    localparam int W = 8;
    localparam longint MAXP = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINN = -(64'sd1 <<< (W - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_sm_mul_if #(.WIDTH(W)) if0 ();
    seq_sm_mul_if #(.WIDTH(W)) if1 ();

    seq_sm_mul #(.WIDTH(W), .SAT_MODE(1'b0)) u_wrap (.clk_i(clk), .rst_i(rst), .mul_io(if0));
    seq_sm_mul #(.WIDTH(W), .SAT_MODE(1'b1)) u_sat  (.clk_i(clk), .rst_i(rst), .mul_io(if1));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic         st_v = 1'b0;
    logic [W-1:0] a_v = '0, b_v = '0;
    logic         sa_v = 1'b0, sb_v = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sa, input logic sb, input logic st);
        a_v = a; b_v = b; sa_v = sa; sb_v = sb; st_v = st;
        if0.a = a; if0.b = b; if0.sign_a = sa; if0.sign_b = sb; if0.start = st;
        if1.a = a; if1.b = b; if1.sign_a = sa; if1.sign_b = sb; if1.start = st;
    endtask

    // Reference: plain integer product, signed value, range test.
    function automatic void model_mul(input int unsigned a, input int unsigned b,
                                      input bit sa, input bit sb,
                                      output logic [2*W-1:0] mag, output bit sg, output bit ov,
                                      output logic [W-1:0] r_wrap, output logic [W-1:0] r_sat);
        longint unsigned p;
        longint s;
        p   = longint'(a) * longint'(b);
        sg  = (sa ^ sb) && (p != 0);
        s   = sg ? -longint'(p) : longint'(p);
        ov  = (s > MAXP) || (s < MINN);
        mag = p[2*W-1:0];
        r_wrap = s[W-1:0];
        if (ov) r_sat = sg ? MINN[W-1:0] : MAXP[W-1:0];
        else    r_sat = s[W-1:0];
    endfunction

    int             busy_left = 0;
    bit             m_done = 0;
    logic [2*W-1:0] m_mag = '0, p_mag = '0;
    bit             m_sign = 0, p_sign = 0, m_ovf = 0, p_ovf = 0;
    logic [W-1:0]   m_rw = '0, m_rs = '0, p_rw = '0, p_rs = '0;

    always @(posedge clk) begin
        if (rst) begin
            busy_left = 0; m_done = 0;
            m_mag = '0; m_sign = 0; m_ovf = 0; m_rw = '0; m_rs = '0;
        end else if (busy_left > 0) begin
            busy_left--;
            m_done = (busy_left == 0);
            if (m_done) begin
                m_mag = p_mag; m_sign = p_sign; m_ovf = p_ovf; m_rw = p_rw; m_rs = p_rs;
            end
        end else begin
            m_done = 0;
            if (st_v) begin
                model_mul(a_v, b_v, sa_v, sb_v, p_mag, p_sign, p_ovf, p_rw, p_rs);
                busy_left = W;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_wrap", 64'(if0.busy), 64'(busy_left > 0));
            chk("busy_sat",  64'(if1.busy), 64'(busy_left > 0));
            chk("done_wrap", 64'(if0.done), 64'(m_done));
            chk("done_sat",  64'(if1.done), 64'(m_done));
            chk("mag_wrap",  64'(if0.prod_mag), 64'(m_mag));
            chk("mag_sat",   64'(if1.prod_mag), 64'(m_mag));
            chk("sign_wrap", 64'(if0.prod_sign), 64'(m_sign));
            chk("sign_sat",  64'(if1.prod_sign), 64'(m_sign));
            chk("ovf_wrap",  64'(if0.ovf), 64'(m_ovf));
            chk("ovf_sat",   64'(if1.ovf), 64'(m_ovf));
            chk("out_wrap",  64'(if0.res), 64'(m_rw));
            chk("out_sat",   64'(if1.res), 64'(m_rs));
        end
    end

    task automatic wait_done(output int lat);
        lat = 1;
        while (!if0.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!if0.done) chk("done_timeout", 64'(if0.done), 64'd1);
    endtask

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sa, input logic sb, output int lat);
        @(posedge clk); #1;
        drive(a, b, sa, sb, 1'b1);
        @(posedge clk); #1;
        drive(a, b, sa, sb, 1'b0);
        wait_done(lat);
    endtask

    task automatic lit(input string nm, input logic [15:0] mag, input logic sg,
                       input logic [7:0] rw, input logic [7:0] rs, input logic ov);
        chk({nm, "_mag"}, 64'(if0.prod_mag), 64'(mag));
        chk({nm, "_sign"}, 64'(if0.prod_sign), 64'(sg));
        chk({nm, "_outw"}, 64'(if0.res), 64'(rw));
        chk({nm, "_outs"}, 64'(if1.res), 64'(rs));
        chk({nm, "_ovf"}, 64'(if1.ovf), 64'(ov));
    endtask

    initial begin
        int lat, n, k;
        logic [W-1:0] ra, rb;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        lit("reset", 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("reset_busy", 64'(if0.busy), 64'd0);
        rst = 1'b0;

        do_mul(8'd5, 8'd6, 1'b0, 1'b0, lat);
        chk("latency", 64'(lat), 64'd9);
        lit("5x6", 16'h001E, 1'b0, 8'h1E, 8'h1E, 1'b0);

        do_mul(8'd3, 8'd7, 1'b1, 1'b0, lat);
        lit("n3x7", 16'h0015, 1'b1, 8'hEB, 8'hEB, 1'b0);

        do_mul(8'd16, 8'd8, 1'b1, 1'b0, lat);
        lit("n16x8", 16'h0080, 1'b1, 8'h80, 8'h80, 1'b0);

        do_mul(8'd16, 8'd8, 1'b0, 1'b0, lat);
        lit("p16x8", 16'h0080, 1'b0, 8'h80, 8'h7F, 1'b1);

        do_mul(8'd255, 8'd255, 1'b0, 1'b1, lat);
        lit("n255x255", 16'hFE01, 1'b1, 8'hFF, 8'h80, 1'b1);

        do_mul(8'd0, 8'd5, 1'b0, 1'b1, lat);
        lit("0xn5", 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0);

        // start pulse during RUN with other operands must be ignored
        @(posedge clk); #1; drive(8'd5, 8'd6, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1; drive(8'd9, 8'd9, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1; drive(8'd9, 8'd9, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1; drive(8'd9, 8'd9, 1'b1, 1'b0, 1'b0);
        wait_done(lat);
        lit("ignore", 16'h001E, 1'b0, 8'h1E, 8'h1E, 1'b0);

        // start held high through DONE: back-to-back
        @(posedge clk); #1; drive(8'd2, 8'd3, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1; drive(8'd4, 8'd5, 1'b0, 1'b0, 1'b1);
        wait_done(lat);
        lit("b2b_first", 16'h0006, 1'b0, 8'h06, 8'h06, 1'b0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!if0.done && n < 40);
        chk("b2b_gap", 64'(n), 64'(W + 1));
        lit("b2b_second", 16'h0014, 1'b0, 8'h14, 8'h14, 1'b0);
        drive(8'd4, 8'd5, 1'b0, 1'b0, 1'b0);
        wait_done(lat);
        n = 0;
        while ((if0.busy || if0.done) && n < 40) begin @(posedge clk); #1; n++; end
        chk("b2b_idle", 64'(if0.busy), 64'd0);

        // reset in the 4th RUN cycle
        @(posedge clk); #1; drive(8'd100, 8'd3, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1; drive(8'd100, 8'd3, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lit("rst_mid", 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("rst_mid_busy", 64'(if0.busy), 64'd0);
        for (int i = 0; i < W + 3; i++) begin
            chk("rst_no_done", 64'(if0.done), 64'd0);
            @(posedge clk); #1;
        end
        do_mul(8'd12, 8'd11, 1'b0, 1'b0, lat);
        chk("post_rst_latency", 64'(lat), 64'd9);
        lit("post_rst", 16'h0084, 1'b0, 8'h84, 8'h7F, 1'b1);

        // randomized traffic; the per-cycle compare carries the checking
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            k = $urandom_range(0, 4);
            ra = (k == 0) ? 8'd0 : (k == 1) ? 8'd255 : (k == 2) ? 8'd128 : 8'($urandom);
            k = $urandom_range(0, 4);
            rb = (k == 0) ? 8'd1 : (k == 1) ? 8'd255 : (k == 2) ? 8'd8 : 8'($urandom);
            drive(ra, rb, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0));
            rst = ($urandom_range(0, 249) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        repeat (W + 4) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
